// File: rtl/bram_dp_clr.sv
// Simple-dual-port block RAM with registered addresses, read-valid pipeline and a zero-fill clear sequencer.
// Optional macro BRAM_DP_CLR_OUTREG_EN adds a registered output stage (read latency 2).
module bram_dp_clr #(
    parameter int unsigned DW         = 36,
    parameter int unsigned AW         = 11,
    parameter int unsigned CLR_ON_RST = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_din,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          clr_start,
    output logic [DW-1:0] wr_dout,
    output logic [DW-1:0] rd_dout,
    output logic          rd_vld,
    output logic          busy
);

    localparam int unsigned DEPTH    = 2**AW;
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          auto_q;
    logic [AW-1:0] reg_wra, reg_rda;
    logic          vld_q;

    logic [DW-1:0] ram [DEPTH];
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            auto_q  <= (CLR_ON_RST != 0);
            reg_wra <= '0;
            reg_rda <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= 1'b0;
            reg_wra <= wr_addr;
            reg_rda <= rd_addr;
            vld_q   <= rd_en;
        end
    end

    // auto_q stands in for clr_start on the first edge after reset when CLR_ON_RST is set
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start || auto_q) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_we = wr_en;
        ram_wa = wr_addr;
        ram_wd = wr_din;
        if (state_q == S_CLEAR) begin
            ram_we = 1'b1;
            ram_wa = cnt_q[AW-1:0];
            ram_wd = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_wa] <= ram_wd;
        end
    end

    assign busy = (state_q == S_CLEAR);

`ifdef BRAM_DP_CLR_OUTREG_EN
    logic [DW-1:0] rd_q, wr_q;
    logic          vld2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            vld2_q <= 1'b0;
        end else begin
            rd_q   <= ram[reg_rda];
            wr_q   <= ram[reg_wra];
            vld2_q <= vld_q;
        end
    end

    assign rd_dout = rd_q;
    assign wr_dout = wr_q;
    assign rd_vld  = vld2_q;
`else
    assign rd_dout = ram[reg_rda];
    assign wr_dout = ram[reg_wra];
    assign rd_vld  = vld_q;
`endif

endmodule

// File: doc/bram_dp_clr.md
# bram_dp_clr

Parametrised simple-dual-port block RAM with registered read/write addresses, a read-valid pipeline, and a built-in memory-clear sequencer. Generalises the fixed 36×2048 NTT coefficient RAM to arbitrary width and depth. Used as the coefficient and twiddle buffer between NTT butterfly stages. The clear sequencer re-zeroes the buffer between polynomial jobs without occupying the datapath controller.

## Interface
- `DW`, default 36: data width in bits.
- `AW`, default 11: address width; depth `DEPTH = 2**AW`.
- `CLR_ON_RST`, default 0: when 1, a full clear starts automatically on the first clock edge after reset deasserts.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write address; also the address for `wr_dout`.
- `wr_din`  in  DW  write data.
- `rd_en`  in  1  read request; qualifies `rd_vld` only.
- `rd_addr`  in  AW  read address.
- `clr_start`  in  1  one-cycle pulse that requests a full memory clear.
- `wr_dout`  out  DW  data at the registered write address.
- `rd_dout`  out  DW  data at the registered read address.
- `rd_vld`  out  1  `rd_dout` corresponds to an `rd_en` request.
- `busy`  out  1  clear sequencer active.

## Operation
- Storage: `DEPTH` words of `DW` bits. Reset does not initialise memory contents.
- Write: when `wr_en`=1 and `busy`=0, the edge writes `ram[wr_addr] <= wr_din`.
- When `busy`=1, external writes are dropped silently.
- Address registers: `reg_wra <= wr_addr` and `reg_rda <= rd_addr` load every cycle, unconditionally.
  - `wr_dout = ram[reg_wra]`.
  - `rd_dout = ram[reg_rda]`.
- Read-during-write to the same address: the output shows the new data (write-through), because the write and the address register update on the same edge.
- `rd_vld` is `rd_en` delayed by the read latency. It is independent of `busy`.
- Clear FSM has two states, IDLE and CLEAR.
  - In IDLE, `clr_start`=1 moves to CLEAR and sets `clr_cnt`=0.
  - In CLEAR, each cycle writes 0 to `ram[clr_cnt]` and increments `clr_cnt`. The cycle that writes `clr_cnt`=DEPTH-1 returns to IDLE.
  - `clr_start` is ignored while in CLEAR; there is no queueing.
- Reads remain legal during CLEAR and return whatever the memory currently holds: cleared words read 0, uncleared words read old data.
- `clr_cnt` is AW+1 bits wide so the terminal compare does not wrap.

## Timing
- Read latency is 1 cycle: an address applied before edge N appears on `rd_dout` after edge N. `rd_vld` follows the same latency.
- `busy` rises on the edge that accepts `clr_start`.
- `busy` stays high for exactly DEPTH cycles. It falls on the edge that performs the final zero-write.
- `clr_start` is sampled in the cycle `busy` falls. Back-to-back clears therefore have a gap of at least 1 cycle.
- Reset values, while `rst_n`=0 at an edge:
  - `reg_wra` and `reg_rda` = 0, so outputs show `ram[0]`.
  - `rd_vld` = 0, `busy` = 0, FSM = IDLE, `clr_cnt` = 0.
  - Output registers (if configured) = 0.
- Reset during CLEAR aborts immediately and leaves memory partially cleared.
  - With `CLR_ON_RST`=1, the clear restarts from address 0 on the first edge with `rst_n`=1. `busy` is 1 after that edge.
- Simultaneous `clr_start` and `wr_en` in IDLE: the write executes, and clearing starts on the following cycles.

## Configuration
- Macro: `BRAM_DP_CLR_OUTREG_EN`.
- Defined: adds a registered output stage on `rd_dout`, `wr_dout` and `rd_vld`, each reset to 0.
  - Read latency becomes 2 cycles.
  - Same-address read-during-write still returns the new data.
- Undefined: outputs are driven directly from memory, with 1-cycle latency.
- `busy` timing is identical in both builds.

## Test plan
- Basic read/write, DW=36, AW=11:
  - Stimulus: write 0x123456789 to address 5; next cycle set `rd_addr`=5 with `rd_en`=1.
  - Required: 1 cycle later `rd_dout`=0x123456789 and `rd_vld`=1. With OUTREG, 2 cycles later.
- Write-through:
  - Stimulus: on the same edge, write 0xABC to address 7 with `rd_addr`=7.
  - Required: next cycle `rd_dout`=0xABC and `wr_dout`=0xABC.
- Full clear:
  - Stimulus: fill addresses 0..2047 with address+1, then pulse `clr_start`.
  - Required: `busy` is high for exactly 2048 cycles; afterwards every address reads 0.
- Write blocked during clear:
  - Stimulus: at clear cycle 100, write 0x5 to address 2000.
  - Required: after clear, address 2000 reads 0. Reading address 1999 at clear cycle 10 returns 2000, the old value.
- Reset mid-clear:
  - Stimulus: assert `rst_n`=0 at clear cycle 50.
  - Required: `busy`=0 next edge; address 10 reads 0; address 1000 reads its old value.
  - With `CLR_ON_RST`=1: `busy` rises on the first edge after release and stays high for 2048 cycles.
- Ignored restart:
  - Stimulus: pulse `clr_start` during CLEAR.
  - Required: `busy` duration is unchanged at 2048 cycles, and no second clear follows.
